// File: rtl/carregador_memoria_instrucoes_pkg.sv
// rtl/carregador_memoria_instrucoes_pkg.sv - shared types and constants for the instruction loader
package carregador_memoria_instrucoes_pkg;

  localparam int LARGURA      = 8;
  localparam int PROFUNDIDADE = 256;

  localparam logic [LARGURA-1:0] INSTR_NULA = 8'h00;

  typedef enum logic [2:0] {
    ESPERA_TAM,
    CARGA,
    CHECK,
    EXECUTA,
    ERRO
  } estado_t;

endpackage

// File: rtl/carregador_memoria_instrucoes_memoria.sv
// rtl/carregador_memoria_instrucoes_memoria.sv - 256x8 store, synchronous write, asynchronous read
module memoria_instrucoes_256x8
  import carregador_memoria_instrucoes_pkg::*;
(
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [7:0]         addr_i,
  input  logic [LARGURA-1:0] din_i,
  input  logic [7:0]         raddr_i,
  output logic [LARGURA-1:0] dout_o
);

  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  assign dout_o = mem_q[raddr_i];

endmodule

// File: rtl/carregador_memoria_instrucoes.sv
// rtl/carregador_memoria_instrucoes.sv - byte-serial boot loader and masked instruction read port
module carregador_memoria_instrucoes
  import carregador_memoria_instrucoes_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Endereco,
  output logic [7:0] InstrucaoLida,
  input  logic [7:0] CargaDado,
  input  logic       CargaValida,
  output logic       CargaPronta,
  input  logic       Recarga,
  output logic       ResetProcessador,
  output logic       Erro
);

  estado_t     estado_q, estado_d;
  logic [8:0]  tamanho_q, tamanho_d;
  logic [8:0]  cont_q, cont_d;
  logic [7:0]  soma_q, soma_d;
  logic        rst_proc_q, rst_proc_d;
  logic        erro_q, erro_d;
  logic        mem_we;
  logic        transfer;
  logic [7:0]  mem_dout;

  assign transfer = CargaValida & CargaPronta;

  always_comb begin
    estado_d    = estado_q;
    tamanho_d   = tamanho_q;
    cont_d      = cont_q;
    soma_d      = soma_q;
    mem_we      = 1'b0;
    CargaPronta = 1'b0;
    case (estado_q)
      ESPERA_TAM: begin
        CargaPronta = 1'b1;
        if (transfer) begin
          tamanho_d = (CargaDado == 8'h00) ? 9'd256 : {1'b0, CargaDado};
          soma_d    = CargaDado;
          cont_d    = 9'd0;
          estado_d  = CARGA;
        end
      end
      CARGA: begin
        CargaPronta = 1'b1;
        if (transfer) begin
          mem_we = 1'b1;
          soma_d = soma_q ^ CargaDado;
          cont_d = cont_q + 9'd1;
          // 9-bit compare so a 256-byte program ends at 255 instead of wrapping
          if (cont_q == tamanho_q - 9'd1) begin
            estado_d = CHECK;
          end
        end
      end
      CHECK: begin
        CargaPronta = 1'b1;
        if (transfer) begin
          estado_d = (CargaDado == soma_q) ? EXECUTA : ERRO;
        end
      end
      EXECUTA, ERRO: begin
        if (Recarga) begin
          estado_d = ESPERA_TAM;
        end
      end
      default: estado_d = ESPERA_TAM;
    endcase
    rst_proc_d = (estado_d != EXECUTA);
    erro_d     = (estado_d == ERRO);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado_q   <= ESPERA_TAM;
      tamanho_q  <= 9'd256;
      cont_q     <= 9'd0;
      soma_q     <= 8'h00;
      rst_proc_q <= 1'b1;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      tamanho_q  <= tamanho_d;
      cont_q     <= cont_d;
      soma_q     <= soma_d;
      rst_proc_q <= rst_proc_d;
      erro_q     <= erro_d;
    end
  end

  memoria_instrucoes_256x8 u_memoria (
    .clk_i   (Clock),
    .we_i    (mem_we),
    .addr_i  (cont_q[7:0]),
    .din_i   (CargaDado),
    .raddr_i (Endereco),
    .dout_o  (mem_dout)
  );

  // Stale or partial contents are hidden unless a verified program is running
  assign InstrucaoLida = ((estado_q == EXECUTA) && ({1'b0, Endereco} < tamanho_q))
                         ? mem_dout : INSTR_NULA;

  assign ResetProcessador = rst_proc_q;
  assign Erro             = erro_q;

endmodule

// File: doc/carregador_memoria_instrucoes.md
# carregador_memoria_instrucoes

Instruction store with a byte-serial boot loader, sitting directly upstream of the nRisc core. It accepts a length-prefixed, XOR-checked program over a valid/ready byte stream and writes it into a 256×8 instruction memory. While loading, it holds the core in reset. Once the program verifies, it serves `InstrucaoLida` combinationally from the core's PC address, as required by the single-cycle datapath.

## Interface
Parameters:
- none; data and address widths are fixed at 8 bits. Depth is 256.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Endereco`  in  8  instruction address (core PC).
- `InstrucaoLida`  out  8  instruction byte at `Endereco`.
- `CargaDado`  in  8  loader byte stream.
- `CargaValida`  in  1  `CargaDado` valid.
- `CargaPronta`  out  1  block can accept a byte.
- `Recarga`  in  1  request a new load; honoured only in EXECUTA or ERRO.
- `ResetProcessador`  out  1  registered; drives the core's `Reset`.
- `Erro`  out  1  registered; checksum failure.

## Operation
- A transfer occurs on a rising edge when `CargaValida & CargaPronta`.
- Stream format: length byte L (8'h00 means 256), then L data bytes in order from address 0, then one checksum byte.
- Checksum rule: the checksum byte must equal the XOR of L and all data bytes.
- Internal registers:
  - 9-bit `Tamanho` (1..256)
  - 9-bit address/counter `Cont`
  - 8-bit running XOR `Soma`
- FSM states:
  - ESPERA_TAM: `CargaPronta`=1. On transfer: `Tamanho` ← (L==0 ? 256 : L), `Soma` ← L, `Cont` ← 0, go to CARGA.
  - CARGA: `CargaPronta`=1. On transfer: mem[`Cont`] ← byte, `Soma` ^= byte, `Cont`++. The transfer with `Cont`==`Tamanho`-1 goes to CHECK.
  - CHECK: `CargaPronta`=1. On transfer: byte==`Soma` → EXECUTA, else → ERRO.
  - EXECUTA: `CargaPronta`=0. `Recarga` → ESPERA_TAM.
  - ERRO: `CargaPronta`=0. `Recarga` → ESPERA_TAM.
- `ResetProcessador` = 1 in every state except EXECUTA. `Erro` = 1 only in ERRO.
- Read path, combinational:
  - in EXECUTA with `Endereco` < `Tamanho`: `InstrucaoLida` = mem[`Endereco`];
  - otherwise: 8'h00.
- Memory contents are never cleared. A failed or aborted load leaves partial writes, which are masked by the read rule.
- `Recarga` is ignored in ESPERA_TAM, CARGA and CHECK. `CargaValida` is ignored in EXECUTA and ERRO.

## Timing
- Reset values:
  - state ESPERA_TAM
  - `ResetProcessador`=1, `Erro`=0, `CargaPronta`=1
  - `InstrucaoLida`=8'h00
  - `Tamanho`=256, `Cont`=0, `Soma`=0
- Throughput is one byte per cycle, with no bubbles. A full program of L=N takes N+2 transfers.
- Release: the edge that accepts a good checksum makes `ResetProcessador` drop to 0 and sets `Erro`=0 in the same clock cycle after that edge. The core's first fetch is address 0.
- `Recarga` in EXECUTA: the next edge raises `ResetProcessador` and `CargaPronta`. `InstrucaoLida` is forced to 0 from then on.
- A write in CARGA is visible to reads only after the block reaches EXECUTA.
- If `Reset` is asserted mid-load, all outputs immediately return to their reset values. The stream restarts with a length byte.
- Boundaries:
  - L=8'h00 loads addresses 0..255, and every address is readable.
  - `Cont` must not wrap before reaching CHECK.

## Structure
- Shared package holds:
  - state enum {ESPERA_TAM, CARGA, CHECK, EXECUTA, ERRO}
  - `INSTR_NULA` = 8'h00
  - width constant 8 and depth constant 256
- One sub-module, `memoria_instrucoes_256x8`: synchronous write (we, addr, din) and asynchronous read (raddr, dout). The FSM, counters, checksum and read mask stay in the top level.

## Test plan
- Reset → `ResetProcessador`=1, `CargaPronta`=1, `Erro`=0, `InstrucaoLida`=00 for any `Endereco`.
- Stream 03,41,82,C3,03 one byte per cycle → EXECUTA after the 5th transfer. Expect `ResetProcessador`=0, and `Endereco` 0/1/2/3 → 41/82/C3/00.
- Same stream with checksum 04 → `Erro`=1, `ResetProcessador` stays 1, `CargaPronta`=0, reads 00. Then `Recarga` plus a good stream → EXECUTA, `Erro`=0.
- `CargaValida` toggling with gaps, plus `Recarga` pulses during CARGA → identical result to the gapless load; `Recarga` has no effect.
- L=00 with 256 bytes of value i, checksum = XOR(0, 0..255) = 00 → addresses 0 and 255 read 00 and FF respectively.
- `Reset` asserted after 2 data bytes → immediate return to ESPERA_TAM. A fresh 01,AA,AB stream then yields addr0=AA and addr1=00.
